// File: rtl/calendar_controller.sv
// Day/month calendar sequencer for the century clock, with button-driven set mode.
// Sole source of the year-advance pulse cy1 and the blink strobe for the display.
module calendar_controller #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       day_tick,
   input  logic       leap_year,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] day_unit,
   output logic [3:0] day_ten,
   output logic [3:0] mon_unit,
   output logic [3:0] mon_ten,
   output logic       cy1,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {RUN = 2'd0, SET_DAY = 2'd1, SET_MONTH = 2'd2, SET_YEAR = 2'd3} modeE;

   modeE          mode_q, mode_d;
   logic [3:0]    dayUnit_q, dayTen_q, monUnit_q, monTen_q;
   logic [7:0]    dayBcd_d, monBcd_d;
   logic          cy1_q, cy1_d;
   logic          blink_q, blink_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [4:0]    dayBin, dayN, curLen, newLen;
   logic [3:0]    monBin, monN;

   function automatic logic [4:0] monthLen(input logic [3:0] m, input logic leap);
      case (m)
         4'd2:                       monthLen = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:    monthLen = 5'd30;
         default:                    monthLen = 5'd31;
      endcase
   endfunction

   function automatic logic [7:0] toBcd(input logic [4:0] v);
      logic [3:0] t;
      logic [4:0] u;
      if (v >= 5'd30)      t = 4'd3;
      else if (v >= 5'd20) t = 4'd2;
      else if (v >= 5'd10) t = 4'd1;
      else                 t = 4'd0;
      u = v - 5'(t) * 5'd10;
      toBcd = {t, u[3:0]};
   endfunction

   // Work in binary for the date arithmetic, then re-split into BCD digits for storage.
   always_comb begin
      dayBin  = 5'(dayTen_q) * 5'd10 + 5'(dayUnit_q);
      monBin  = ((monTen_q != 4'd0) ? 4'd10 : 4'd0) + monUnit_q;
      curLen  = monthLen(monBin, leap_year);
      dayN    = dayBin;
      monN    = monBin;
      newLen  = curLen;
      mode_d  = mode_q;
      cy1_d   = 1'b0;
      blink_d = blink_q;
      cnt_d   = cnt_q;

      if (mode_q == RUN && day_tick) begin
         if (dayBin < curLen) begin
            dayN = dayBin + 5'd1;
         end else begin
            dayN = 5'd1;
            if (monBin < 4'd12) begin
               monN = monBin + 4'd1;
            end else begin
               monN  = 4'd1;
               cy1_d = 1'b1;
            end
         end
      end

      // A mode step always beats a simultaneous increment.
      if (btn_mode) begin
         case (mode_q)
            RUN:       mode_d = SET_DAY;
            SET_DAY:   mode_d = SET_MONTH;
            SET_MONTH: mode_d = SET_YEAR;
            default: begin
               mode_d = RUN;
               if (dayBin > curLen) dayN = curLen;
            end
         endcase
      end else if (btn_inc) begin
         case (mode_q)
            SET_DAY:   dayN = (dayBin >= curLen) ? 5'd1 : dayBin + 5'd1;
            SET_MONTH: begin
               monN   = (monBin >= 4'd12) ? 4'd1 : monBin + 4'd1;
               newLen = monthLen(monN, leap_year);
               if (dayBin > newLen) dayN = newLen;
            end
            SET_YEAR:  cy1_d = ~cy1_q;
            default:   ;
         endcase
      end

      if (btn_mode || mode_q == RUN) begin
         cnt_d   = '0;
         blink_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         blink_d = ~blink_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      dayBcd_d = toBcd(dayN);
      monBcd_d = toBcd(5'(monN));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q    <= RUN;
         dayTen_q  <= 4'd0;
         dayUnit_q <= 4'd1;
         monTen_q  <= 4'd0;
         monUnit_q <= 4'd1;
         cy1_q     <= 1'b0;
         blink_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         mode_q    <= mode_d;
         dayTen_q  <= dayBcd_d[7:4];
         dayUnit_q <= dayBcd_d[3:0];
         monTen_q  <= monBcd_d[7:4];
         monUnit_q <= monBcd_d[3:0];
         cy1_q     <= cy1_d;
         blink_q   <= blink_d;
         cnt_q     <= cnt_d;
      end
   end

   assign day_unit = dayUnit_q;
   assign day_ten  = dayTen_q;
   assign mon_unit = monUnit_q;
   assign mon_ten  = monTen_q;
   assign cy1      = cy1_q;
   assign mode     = mode_q;
   assign blink    = blink_q;

endmodule

// File: tb/tb_calendar_controller.sv
// Self-checking bench for calendar_controller: directed calendar scenarios plus a
// randomized run, all compared against an integer-arithmetic calendar model.
module tb_calendar_controller;

   logic       clk = 1'b0;
   logic       reset, dayTick, leapYear, btnMode, btnInc;
   logic [3:0] dayUnit, dayTen, monUnit, monTen;
   logic       cy1, blink;
   logic [1:0] mode;

   int checks = 0;
   int failures = 0;
   int cyCount = 0;
   bit leapVal = 1'b0;
   string phase = "init";

   int mDay, mMon, mMode, mCnt;
   bit mCy1, mBlink;

   calendar_controller #(.BLINK_DIV(4)) dut (
      .clk(clk), .reset(reset), .day_tick(dayTick), .leap_year(leapYear),
      .btn_mode(btnMode), .btn_inc(btnInc),
      .day_unit(dayUnit), .day_ten(dayTen), .mon_unit(monUnit), .mon_ten(monTen),
      .cy1(cy1), .mode(mode), .blink(blink)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s (%s): got %0h expected %0h at %0t", tag, phase, observed, expected, $time);
      end
   endtask

   function automatic int monLen(input int m, input bit leap);
      int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m == 2 && leap) return 29;
      return lens[m-1];
   endfunction

   // The calendar as a person would describe it, in whole days and months.
   task automatic modelUpdate(input bit rst, input bit tick, input bit bm, input bit bi);
      bit modeChanged = 1'b0;
      if (rst) begin
         mDay = 1; mMon = 1; mMode = 0; mCy1 = 0; mBlink = 0; mCnt = 0;
         return;
      end
      mCy1 = 0;
      if (mMode == 0 && tick) begin
         mDay++;
         if (mDay > monLen(mMon, leapVal)) begin
            mDay = 1;
            mMon++;
            if (mMon > 12) begin
               mMon = 1;
               mCy1 = 1;
            end
         end
      end
      if (bm) begin
         if (mMode == 3 && mDay > monLen(mMon, leapVal)) mDay = monLen(mMon, leapVal);
         mMode = (mMode + 1) % 4;
         modeChanged = 1'b1;
      end else if (bi) begin
         if (mMode == 1) begin
            mDay = (mDay % monLen(mMon, leapVal)) + 1;
         end else if (mMode == 2) begin
            mMon = (mMon % 12) + 1;
            if (mDay > monLen(mMon, leapVal)) mDay = monLen(mMon, leapVal);
         end else if (mMode == 3) begin
            mCy1 = 1;
         end
      end
      if (modeChanged || mMode == 0) begin
         mCnt = 0;
         mBlink = 0;
      end else begin
         mCnt++;
         if (mCnt == 4) begin
            mCnt = 0;
            mBlink = !mBlink;
         end
      end
   endtask

   // One clock of stimulus: drive, let the edge pass, then compare at the falling edge.
   task automatic applyStimulus(input bit rst, input bit tick, input bit bm, input bit bi);
      reset = rst; dayTick = tick; btnMode = bm; btnInc = bi; leapYear = leapVal;
      @(posedge clk);
      modelUpdate(rst, tick, bm, bi);
      @(negedge clk);
      checkOutput("date", {16'd0, dayTen, dayUnit, monTen, monUnit},
                  {16'd0, 4'(mDay / 10), 4'(mDay % 10), 4'(mMon / 10), 4'(mMon % 10)});
      checkOutput("cy1", 32'(cy1), 32'(mCy1));
      checkOutput("mode", 32'(mode), 32'(mMode));
      checkOutput("blink", 32'(blink), 32'(mBlink));
      if (cy1 === 1'b1) cyCount++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
   endtask

   // Dial in a date through the set modes, starting and ending in RUN.
   task automatic gotoDate(input int td, input int tm);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 13; i++) begin
         if (mMon == tm) break;
         applyStimulus(0, 0, 0, 1);
      end
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 32; i++) begin
         if (mDay == td) break;
         applyStimulus(0, 0, 0, 1);
      end
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
   endtask

   initial begin
      bit prevInc = 1'b0;

      phase = "reset";
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);

      phase = "january";
      for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 0);
      checkOutput("jan31", {24'd0, dayTen, dayUnit}, 32'h31);
      applyStimulus(0, 1, 0, 0);

      phase = "febNoLeap";
      leapVal = 1'b0;
      gotoDate(28, 2);
      applyStimulus(0, 1, 0, 0);
      checkOutput("mar01", {16'd0, dayTen, dayUnit, monTen, monUnit}, 32'h0103);

      phase = "febLeap";
      leapVal = 1'b1;
      gotoDate(28, 2);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);

      phase = "yearEnd";
      gotoDate(31, 12);
      cyCount = 0;
      applyStimulus(0, 1, 0, 0);
      idle(2);
      checkOutput("cy1Once", 32'(cyCount), 32'd1);

      phase = "monthClamp";
      gotoDate(31, 3);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("apr30", {16'd0, dayTen, dayUnit, monTen, monUnit}, 32'h3004);
      applyStimulus(0, 0, 1, 0);
      cyCount = 0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1);
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("cy1Pulses", 32'(cyCount), 32'd3);
      applyStimulus(0, 0, 1, 0);

      phase = "leapExit";
      leapVal = 1'b1;
      gotoDate(29, 2);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      leapVal = 1'b0;
      applyStimulus(0, 0, 1, 0);
      checkOutput("feb28", {16'd0, dayTen, dayUnit, monTen, monUnit}, 32'h2802);

      phase = "blink";
      applyStimulus(0, 0, 1, 0);
      idle(10);
      applyStimulus(0, 0, 1, 1);
      idle(5);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 0, 1, 1);

      phase = "resetOnCy1";
      gotoDate(31, 12);
      applyStimulus(0, 1, 0, 0);
      checkOutput("cy1High", 32'(cy1), 32'd1);
      applyStimulus(1, 0, 0, 0);
      idle(2);

      phase = "tickWithMode";
      gotoDate(31, 12);
      applyStimulus(0, 1, 1, 0);
      idle(3);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 1, 0);

      phase = "random";
      for (int i = 0; i < 800; i++) begin
         bit rst, tick, bm, bi;
         if ($urandom_range(0, 19) == 0) leapVal = !leapVal;
         rst  = ($urandom_range(0, 149) == 0);
         tick = ($urandom_range(0, 2) == 0);
         bm   = ($urandom_range(0, 9) == 0);
         bi   = !prevInc && ($urandom_range(0, 2) == 0);
         prevInc = bi;
         applyStimulus(rst, tick, bm, bi);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/calendar_controller.md
Name: calendar_controller

Overview:
- Sequences the day/month calendar of the century clock and is the sole source of the year-advance pulse cy1 into the year counter.
- Consumes the daily tick from the hour counter and the leap_year flag returned by the year counter.
- Provides a button-driven set mode for day, month and year, with a blink flag for the display path.
- Outputs day and month as BCD digits for the existing 7-segment decoders.

Parameters:
- BLINK_DIV, 25000000, clk cycles per blink half-period in set modes (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- day_tick  input  1  one-cycle pulse, one per day rollover (from hour counter)
- leap_year  input  1  current year is leap (from year counter), level
- btn_mode  input  1  one-cycle debounced pulse, advances set mode
- btn_inc  input  1  one-cycle debounced pulse, increments selected field
- day_unit  output  4  BCD day units
- day_ten  output  4  BCD day tens (0..3)
- mon_unit  output  4  BCD month units
- mon_ten  output  4  BCD month tens (0..1)
- cy1  output  1  one-cycle year-advance pulse to year counter
- mode  output  2  0=RUN, 1=SET_DAY, 2=SET_MONTH, 3=SET_YEAR
- blink  output  1  display blank strobe for the selected field

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on posedge clk. Reset has priority over every other input.
- Reset values: day=01, month=01, cy1=0, mode=RUN, blink=0, blink counter=0.
- All outputs are registered.
- Month length L(m):
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - February: 29 if leap_year=1 else 28.
  - leap_year is sampled in the same cycle as the event that uses it.
- Day/month are held as BCD digit pairs. Unit digit wraps 9->0 with a carry into the tens digit. Legal ranges: day 01..L(m), month 01..12.

- RUN, on day_tick:
  - day < L(m): day+1.
  - day = L(m) and month < 12: day=01, month+1.
  - day = 31 and month = 12: day=01, month=01, cy1=1 for exactly one cycle.
  - Outputs change, and cy1 asserts, in the cycle after the tick is sampled.
- Set modes:
  - day_tick is ignored in SET_DAY, SET_MONTH and SET_YEAR. Ticks are dropped, not queued.
  - btn_mode steps RUN->SET_DAY->SET_MONTH->SET_YEAR->RUN.
- btn_inc in RUN: ignored.
- btn_inc in SET_DAY: day+1; day = L(m) wraps to 01. No month change.
- btn_inc in SET_MONTH:
  - month+1; month 12 wraps to 01. No cy1.
  - In the same update, day clamps to L(new month) if it exceeds it (e.g. 31 + inc from 03 -> month 04, day 30).
- btn_inc in SET_YEAR: cy1=1 for exactly one cycle. Day/month unchanged.
- On the transition SET_YEAR->RUN, day clamps to L(m) using the leap_year value in that cycle (29 Feb in a non-leap year -> 28 Feb).
- btn_mode and btn_inc in the same cycle: the mode step wins and the inc is dropped.
- day_tick together with btn_mode while in RUN: the tick is processed and the mode becomes SET_DAY. The rollover completes, including any cy1.
- cy1 is never high for two consecutive cycles. Consecutive btn_inc pulses in SET_YEAR produce one cy1 per pulse.
- Blink:
  - In RUN: blink=0 and the counter is held at 0.
  - In set modes: the counter counts 0..BLINK_DIV-1, and blink toggles when the counter wraps.
  - On any mode change: counter=0 and blink=0.
- Reset mid-operation (any mode, cy1 high): all state returns to reset values the next cycle, and cy1 deasserts.

Test Plan:
- Reset, then 30 day_ticks in RUN -> date 31/01. One more tick -> 01/02; cy1 stays 0 throughout.
- Set 28/02 with leap_year=0, one tick -> 01/03. Repeat with leap_year=1 -> 29/02, then another tick -> 01/03.
- Set 31/12, tick -> 01/01 and cy1 high exactly one cycle, in the cycle after the tick.
- SET_MONTH with day 31, month 03, btn_inc -> month 04, day 30. Then btn_mode into SET_YEAR and 3 btn_inc -> exactly 3 single-cycle cy1 pulses.
- Date 29/02 with leap_year=1, enter SET_YEAR, drop leap_year to 0, btn_mode to RUN -> 28/02. In any set mode, day_tick leaves the date unchanged.
- With BLINK_DIV=4 in SET_DAY: blink toggles every 4 cycles. btn_mode and btn_inc in the same cycle -> mode advances with no increment. reset while cy1 is high -> 01/01, RUN, cy1=0 the next cycle.
